pc_fetch_sequencer: RTL and testbench

Owns the architectural program counter and sequences instruction fetch through a request/valid port to instruction memory. Decodes branch class (B, BL, CBZ) on each fetched word and computes the next PC. Hands each instruction downstream over a valid/ready handshake. Emits the link-register write for BL. Sits between the instruction memory and the decode/register-file stage.

---
 rtl/pc_fetch_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Owns the architectural program counter, fetches one instruction word at a
//   time from instruction memory, and hands each word to the decode stage. It
//   decodes the branch class of the issued word (B, BL, CBZ) to pick the next
//   PC, and strobes a link-register write for BL.
//
// Optional build macro: PC_BOUNDS_CHECK_EN
//   When defined, a next_pc outside [0, IMEM_BYTES) or not word aligned is
//   refused. The PC holds, the sticky fault flag sets and the sequencer halts.
//   When undefined, fault is tied low.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-low reset
//   start        leave IDLE and begin fetching
//   halt_req     halt after the instruction being handed off this cycle
//   imem_req     fetch request, held until imem_valid
//   imem_addr    fetch address (the current pc)
//   imem_valid   imem_rdata valid (only looked at while fetching)
//   imem_rdata   fetched instruction word
//   instr_valid  instr / instr_pc valid to downstream
//   instr        issued instruction
//   instr_pc     address of the issued instruction
//   instr_ready  downstream accepts instr
//   cbz_zero     Rt==0 for the issued CBZ, sampled on the handshake cycle
//   lr_we        one-cycle link-register write strobe
//   lr_addr      link register index (X30)
//   lr_data      return address (BL pc + 4)
//   pc           current program counter
//   halted       high while halted
//   fault        sticky bounds fault
module pc_fetch_sequencer #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       IMEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              cbz_zero,
  output logic              lr_we,
  output logic [4:0]        lr_addr,
  output logic [ADDR_W-1:0] lr_data,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALTED
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [31:0]       instr_reg;
  logic [ADDR_W-1:0] instr_pc_reg;
  logic              lr_we_reg;
  logic [ADDR_W-1:0] lr_data_reg;

  logic              handshake;
  logic              fetch_done;
  logic              is_b, is_bl, is_cbz;
  logic [ADDR_W-1:0] off_b, off_cbz;
  logic [ADDR_W-1:0] next_pc;
  logic              oob_next;
  logic              bounds_bad;

  assign handshake  = (state_reg == S_ISSUE) && instr_ready;
  assign fetch_done = (state_reg == S_FETCH) && imem_valid;

  // Branch class decode on the word currently being issued.
  assign is_b   = (instr_reg[31:26] == 6'b000101);
  assign is_bl  = (instr_reg[31:26] == 6'b100101);
  assign is_cbz = (instr_reg[31:24] == 8'b10110100);

  // Word offsets, sign-extended and scaled to bytes.
  assign off_b   = {{(ADDR_W-28){instr_reg[25]}}, instr_reg[25:0], 2'b00};
  assign off_cbz = {{(ADDR_W-21){instr_reg[23]}}, instr_reg[23:5], 2'b00};

  always_comb begin
    next_pc = pc_reg + ADDR_W'(4);
    if (is_b || is_bl) begin
      next_pc = pc_reg + off_b;
    end else if (is_cbz && cbz_zero) begin
      next_pc = pc_reg + off_cbz;
    end
  end

  assign oob_next = (next_pc >= ADDR_W'(IMEM_BYTES)) || (next_pc[1:0] != 2'b00);

`ifdef PC_BOUNDS_CHECK_EN
  assign bounds_bad = handshake && oob_next;
`else
  // The range check has no consumer when the bounds feature is left out.
  logic unused_oob;
  assign unused_oob = oob_next;
  assign bounds_bad = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  if (imem_valid) state_next = S_ISSUE;
      S_ISSUE: begin
        if (handshake) begin
          state_next = (bounds_bad || halt_req) ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg       <= RESET_PC;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
      lr_we_reg    <= 1'b0;
      lr_data_reg  <= '0;
    end else begin
      lr_we_reg <= 1'b0;
      if (fetch_done) begin
        instr_reg    <= imem_rdata;
        instr_pc_reg <= pc_reg;
      end
      if (handshake) begin
        // A refused target leaves the PC where it is.
        if (!bounds_bad) begin
          pc_reg <= next_pc;
        end
        // The link write happens even when the branch target is refused.
        if (is_bl) begin
          lr_we_reg   <= 1'b1;
          lr_data_reg <= instr_pc_reg + ADDR_W'(4);
        end
      end
    end
  end

`ifdef PC_BOUNDS_CHECK_EN
  logic fault_reg;
  always_ff @(posedge clk) begin
    if (!rst) begin
      fault_reg <= 1'b0;
    end else if (bounds_bad) begin
      fault_reg <= 1'b1;
    end
  end
  assign fault = fault_reg;
`else
  assign fault = 1'b0;
`endif

  assign imem_req    = (state_reg == S_FETCH);
  assign imem_addr   = pc_reg;
  assign instr_valid = (state_reg == S_ISSUE);
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign lr_we       = lr_we_reg;
  assign lr_addr     = 5'd30;
  assign lr_data     = lr_data_reg;
  assign pc          = pc_reg;
  assign halted      = (state_reg == S_HALTED);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: a small program is laid out in a bench memory
// so that one pass walks sequential code, B forward/backward, BL, both CBZ
// outcomes and the 0x3FC boundary. A transaction-level model predicts the
// outputs every cycle; literal expectations pin the fetch address sequence,
// the link write, backpressure, halt and reset behaviour.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] NOP   = 32'hD503201F;
  localparam logic [31:0] CBZ_W = 32'hB4000060;
  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_ISSUE = 2;
  localparam int P_HALT  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        imem_valid = 1'b0;
  logic        instr_ready = 1'b0;
  logic        cbz_zero = 1'b0;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid, lr_we, halted, fault;
  logic [31:0] imem_addr, instr, instr_pc, lr_data, pc;
  logic [4:0]  lr_addr;

  pc_fetch_sequencer #(
    .ADDR_W(32), .RESET_PC(32'h0), .IMEM_BYTES(1024)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .cbz_zero(cbz_zero),
    .lr_we(lr_we), .lr_addr(lr_addr), .lr_data(lr_data), .pc(pc),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Bench instruction memory, 4 KB, NOP everywhere not explicitly programmed.
  logic [31:0] mem [0:1023];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd4096) return mem[a[11:2]];
    return NOP;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Architectural next PC from the branch rules, in plain integer arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] w, input logic [31:0] p,
                                             input logic z);
    int off;
    off = 1;
    if (w[31:26] == 6'b000101 || w[31:26] == 6'b100101) begin
      off = $signed(w[25:0]);
    end else if (w[31:24] == 8'hB4 && z) begin
      off = $signed(w[23:5]);
    end
    return p + 32'(off * 4);
  endfunction

  // Transaction-level model: which phase the sequencer is in and what it holds.
  int          m_phase = P_IDLE;
  logic [31:0] m_pc, m_instr, m_instr_pc, m_lr_data;
  logic        m_lr_we, m_fault;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    logic [31:0] nxt;
    chk_en  <= 1'b1;
    m_lr_we <= 1'b0;
    if (!rst) begin
      m_phase    <= P_IDLE;
      m_pc       <= 32'h0;
      m_instr    <= 32'h0;
      m_instr_pc <= 32'h0;
      m_lr_data  <= 32'h0;
      m_fault    <= 1'b0;
    end else if (m_phase == P_IDLE) begin
      if (start) m_phase <= P_FETCH;
    end else if (m_phase == P_FETCH) begin
      if (imem_valid) begin
        m_instr    <= mem_word(m_pc);
        m_instr_pc <= m_pc;
        m_phase    <= P_ISSUE;
      end
    end else if (m_phase == P_ISSUE) begin
      if (instr_ready) begin
        nxt = model_next(m_instr, m_pc, cbz_zero);
        if (m_instr[31:26] == 6'b100101) begin
          m_lr_we   <= 1'b1;
          m_lr_data <= m_instr_pc + 32'd4;
        end
        m_phase <= halt_req ? P_HALT : P_FETCH;
`ifdef PC_BOUNDS_CHECK_EN
        if (nxt >= 32'd1024 || (nxt % 4) != 0) begin
          m_fault <= 1'b1;
          m_phase <= P_HALT;
        end else begin
          m_pc <= nxt;
        end
`else
        m_pc <= nxt;
`endif
      end
    end
  end

  // Memory responder and CBZ operand: first CBZ visit sees Rt==0, later ones not.
  int lat = 1;
  int req_age = 0;
  int cbz_visits = 0;
  logic [31:0] fetch_log[$];
  logic [31:0] lr_log[$];

  always @(negedge clk) begin
    if (imem_req === 1'b1) req_age = req_age + 1;
    else req_age = 0;
    imem_valid = (imem_req === 1'b1) && (req_age > lat);
    cbz_zero   = (cbz_visits == 0);
  end

  always @(posedge clk) begin
    if (rst && imem_req && imem_valid) fetch_log.push_back(imem_addr);
    if (rst && instr_valid && instr_ready && instr == CBZ_W) cbz_visits++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req", imem_req, m_phase == P_FETCH);
      if (m_phase == P_FETCH) check("imem_addr", imem_addr, m_pc);
      check("instr_valid", instr_valid, m_phase == P_ISSUE);
      check("instr", instr, m_instr);
      check("instr_pc", instr_pc, m_instr_pc);
      check("pc", pc, m_pc);
      check("lr_we", lr_we, m_lr_we);
      check("lr_data", lr_data, m_lr_data);
      check("lr_addr", lr_addr, 5'd30);
      check("halted", halted, m_phase == P_HALT);
      check("fault", fault, m_fault);
      if (lr_we) lr_log.push_back(lr_data);
    end
  end

  logic [31:0] exp_fetch [15] = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010,
                                  32'h020, 32'h01C, 32'h040, 32'h080, 32'h100,
                                  32'h10C, 32'h100, 32'h104, 32'h3FC, 32'h400};

  initial begin
    int n_fetch;
    logic seen;
    for (int i = 0; i < 1024; i++) mem[i] = NOP;
    mem[32'h010 >> 2] = 32'h14000004;  // B +0x10      -> 0x20
    mem[32'h020 >> 2] = 32'h17FFFFFF;  // B -0x4       -> 0x1C
    mem[32'h01C >> 2] = 32'h14000009;  // B +0x24      -> 0x40
    mem[32'h040 >> 2] = 32'h94000010;  // BL +0x40     -> 0x80
    mem[32'h080 >> 2] = 32'h14000020;  // B +0x80      -> 0x100
    mem[32'h100 >> 2] = CBZ_W;         // CBZ +0xC
    mem[32'h10C >> 2] = 32'h17FFFFFD;  // B -0xC       -> 0x100
    mem[32'h104 >> 2] = 32'h140000BE;  // B +0x2F8     -> 0x3FC
    mem[32'h3FC >> 2] = 32'h14000001;  // B +0x4       -> 0x400

    // Reset held for two cycles.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_pc", pc, 32'h0);
      check("rst_imem_req", imem_req, 1'b0);
      check("rst_instr_valid", instr_valid, 1'b0);
      check("rst_lr_we", lr_we, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_fault", fault, 1'b0);
    end
    rst = 1'b1;
    start = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;

`ifdef PC_BOUNDS_CHECK_EN
    n_fetch = 14;
`else
    n_fetch = 15;
`endif
    for (int c = 0; c < 600; c++) begin
      if (fetch_log.size() >= n_fetch) break;
      @(negedge clk);
    end
    check("fetch_count", fetch_log.size() >= n_fetch, 1'b1);
    for (int i = 0; i < n_fetch; i++) begin
      if (i < fetch_log.size()) check($sformatf("fetch_addr[%0d]", i), fetch_log[i], exp_fetch[i]);
    end

`ifdef PC_BOUNDS_CHECK_EN
    for (int c = 0; c < 20; c++) begin
      if (halted) break;
      @(negedge clk);
    end
    check("bounds_fault", fault, 1'b1);
    check("bounds_halted", halted, 1'b1);
    check("bounds_pc", pc, 32'h3FC);
    check("bounds_no_req", imem_req, 1'b0);
`else
    check("nobounds_fault", fault, 1'b0);
`endif
    check("bl_lr_count", lr_log.size(), 1);
    if (lr_log.size() > 0) check("bl_lr_data", lr_log[0], 32'h44);

    // Reset while a fetch is outstanding (or while halted in the bounded build).
    lat = 3;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (imem_req || halted) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_fetch_or_halt", seen, 1'b1);
    check("pre_reset_pc_nonzero", pc != 32'h0, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_pc", pc, 32'h0);
    check("midrst_imem_req", imem_req, 1'b0);
    check("midrst_instr_valid", instr_valid, 1'b0);
    check("midrst_halted", halted, 1'b0);
    check("midrst_fault", fault, 1'b0);

    // Backpressure, then handshake with halt.
    rst = 1'b1;
    instr_ready = 1'b0;
    start = 1'b1;
    lat = 0;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (instr_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("issue_reached", seen, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("bp_instr", instr, NOP);
      check("bp_instr_pc", instr_pc, 32'h0);
      check("bp_imem_req", imem_req, 1'b0);
      check("bp_instr_valid", instr_valid, 1'b1);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    halt_req = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    halt_req = 1'b0;
    check("halt_halted", halted, 1'b1);
    check("halt_pc", pc, 32'h4);
    check("halt_imem_req", imem_req, 1'b0);
    check("halt_instr_valid", instr_valid, 1'b0);

    // start and halt_req are ignored once halted.
    start = 1'b1;
    halt_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("halted_no_req", imem_req, 1'b0);
      check("halted_stays", halted, 1'b1);
    end
    start = 1'b0;
    halt_req = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
